// File: rtl/cv32e40x_bch_resolve.sv
// Branch resolution table: tracks in-flight conditional branches from ID to EX and
// raises a registered redirect on misprediction. Optional counters via CV32E40X_BCH_STATS_EN.
module cv32e40x_bch_resolve #(
    parameter int unsigned DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_bch_alloc_i,
    input  logic [31:0] pc_id_i,
    input  logic        is_compressed_i,
    input  logic [31:0] bch_target_i,
    input  logic        bch_prediction_id_i,
    input  logic        ex_bch_valid_i,
    input  logic        ex_bch_taken_i,
    input  logic        kill_i,
    output logic        pred_redirect_o,
    output logic [31:0] pred_target_o,
    output logic        mispredict_o,
    output logic [31:0] mispredict_pc_o,
    output logic        stall_id_o,
    output logic        empty_o,
    output logic        err_o
`ifdef CV32E40X_BCH_STATS_EN
    ,
    output logic [31:0] bch_cnt_o,
    output logic [31:0] mispred_cnt_o
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic          pred_mem [DEPTH];
    logic [31:0]   tgt_mem  [DEPTH];
    logic [31:0]   ft_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          mispredict_q;
    logic [31:0]   mispredict_pc_q;
    logic          err_q;

    logic          empty;
    logic          full;
    logic          stall;
    logic          pop;
    logic          push;
    logic          mismatch;
    logic          err_evt;
    logic [31:0]   fall_through;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty        = (count_q == '0);
        full         = (count_q == CNT_FULL);
        stall        = full & ~ex_bch_valid_i;
        pop          = ex_bch_valid_i & ~empty;
        err_evt      = ex_bch_valid_i & empty & ~kill_i;
        mismatch     = pop & (pred_mem[rd_ptr_q] != ex_bch_taken_i);
        // A mispredict flushes everything younger, including the branch arriving now.
        push         = id_bch_alloc_i & ~stall & ~kill_i & ~mismatch;
        fall_through = pc_id_i + (is_compressed_i ? 32'd2 : 32'd4);
    end

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    // NOTE: entry storage has no reset; validity is carried entirely by count/pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            pred_mem[wr_ptr_q] <= bch_prediction_id_i;
            tgt_mem[wr_ptr_q]  <= bch_target_i;
            ft_mem[wr_ptr_q]   <= fall_through;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            mispredict_q    <= 1'b0;
            mispredict_pc_q <= '0;
            err_q           <= 1'b0;
        end else begin
            mispredict_q <= 1'b0;
            if (kill_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else if (mismatch) begin
                wr_ptr_q        <= '0;
                rd_ptr_q        <= '0;
                count_q         <= '0;
                mispredict_q    <= 1'b1;
                mispredict_pc_q <= ex_bch_taken_i ? tgt_mem[rd_ptr_q] : ft_mem[rd_ptr_q];
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
            if (err_evt) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef CV32E40X_BCH_STATS_EN
    logic [31:0] bch_cnt_q;
    logic [31:0] mispred_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bch_cnt_q     <= '0;
            mispred_cnt_q <= '0;
        end else if (!kill_i) begin
            if (pop) begin
                bch_cnt_q <= bch_cnt_q + 32'd1;
            end
            if (mismatch) begin
                mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
        end
    end

    assign bch_cnt_o     = bch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`endif

    assign pred_redirect_o = id_bch_alloc_i & bch_prediction_id_i & ~stall & ~kill_i;
    assign pred_target_o   = bch_target_i;
    assign mispredict_o    = mispredict_q;
    assign mispredict_pc_o = mispredict_pc_q;
    assign stall_id_o      = stall;
    assign empty_o         = empty;
    assign err_o           = err_q;

endmodule

// File: tb/tb_cv32e40x_bch_resolve.sv
// Self-checking bench for cv32e40x_bch_resolve: directed cases plus random traffic
// against a queue-based reference model.
module tb_cv32e40x_bch_resolve;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_bch_alloc_i;
    logic [31:0] pc_id_i;
    logic        is_compressed_i;
    logic [31:0] bch_target_i;
    logic        bch_prediction_id_i;
    logic        ex_bch_valid_i;
    logic        ex_bch_taken_i;
    logic        kill_i;
    logic        pred_redirect_o;
    logic [31:0] pred_target_o;
    logic        mispredict_o;
    logic [31:0] mispredict_pc_o;
    logic        stall_id_o;
    logic        empty_o;
    logic        err_o;
`ifdef CV32E40X_BCH_STATS_EN
    logic [31:0] bch_cnt_o;
    logic [31:0] mispred_cnt_o;
`endif

    always #5 clk = ~clk;

    cv32e40x_bch_resolve #(.DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .id_bch_alloc_i      (id_bch_alloc_i),
        .pc_id_i             (pc_id_i),
        .is_compressed_i     (is_compressed_i),
        .bch_target_i        (bch_target_i),
        .bch_prediction_id_i (bch_prediction_id_i),
        .ex_bch_valid_i      (ex_bch_valid_i),
        .ex_bch_taken_i      (ex_bch_taken_i),
        .kill_i              (kill_i),
        .pred_redirect_o     (pred_redirect_o),
        .pred_target_o       (pred_target_o),
        .mispredict_o        (mispredict_o),
        .mispredict_pc_o     (mispredict_pc_o),
        .stall_id_o          (stall_id_o),
        .empty_o             (empty_o),
        .err_o               (err_o)
`ifdef CV32E40X_BCH_STATS_EN
        ,
        .bch_cnt_o           (bch_cnt_o),
        .mispred_cnt_o       (mispred_cnt_o)
`endif
    );

    typedef struct {
        logic        pred;
        logic [31:0] tgt;
        logic [31:0] ft;
    } ent_t;

    ent_t        mq[$];
    logic        m_err;
    logic        m_mp;
    logic [31:0] m_mpc;
    logic [31:0] m_bcnt;
    logic [31:0] m_mcnt;
    int          tests_run;
    int          tests_failed;

    task automatic model_clear();
        mq.delete();
        m_err  = 1'b0;
        m_mp   = 1'b0;
        m_mpc  = '0;
        m_bcnt = '0;
        m_mcnt = '0;
    endtask

    task automatic drive_idle();
        id_bch_alloc_i      = 1'b0;
        pc_id_i             = '0;
        is_compressed_i     = 1'b0;
        bch_target_i        = '0;
        bch_prediction_id_i = 1'b0;
        ex_bch_valid_i      = 1'b0;
        ex_bch_taken_i      = 1'b0;
        kill_i              = 1'b0;
    endtask

    // One clock of stimulus: check combinational outputs, advance model, check registered outputs.
    task automatic step(input logic a, input logic [31:0] pc, input logic c, input logic [31:0] tgt,
                        input logic p, input logic ev, input logic tk, input logic k);
        logic e_stall;
        logic e_redir;
        logic mism;
        ent_t e;
        id_bch_alloc_i      = a;
        pc_id_i             = pc;
        is_compressed_i     = c;
        bch_target_i        = tgt;
        bch_prediction_id_i = p;
        ex_bch_valid_i      = ev;
        ex_bch_taken_i      = tk;
        kill_i              = k;
        #1;
        e_stall = (mq.size() == DEPTH) && !ev;
        e_redir = a && p && !e_stall && !k;
        tests_run += 4;
        if (stall_id_o !== e_stall) begin
            tests_failed++;
            $display("FAIL stall_id: got %b exp %b", stall_id_o, e_stall);
        end
        if (empty_o !== (mq.size() == 0)) begin
            tests_failed++;
            $display("FAIL empty_pre: got %b exp %b", empty_o, mq.size() == 0);
        end
        if (pred_redirect_o !== e_redir) begin
            tests_failed++;
            $display("FAIL pred_redirect: got %b exp %b", pred_redirect_o, e_redir);
        end
        if (pred_target_o !== tgt) begin
            tests_failed++;
            $display("FAIL pred_target: got %h exp %h", pred_target_o, tgt);
        end

        m_mp = 1'b0;
        mism = 1'b0;
        if (k) begin
            mq.delete();
        end else begin
            if (ev) begin
                if (mq.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    e = mq.pop_front();
                    m_bcnt++;
                    if (e.pred != tk) begin
                        mism  = 1'b1;
                        m_mp  = 1'b1;
                        m_mpc = tk ? e.tgt : e.ft;
                        m_mcnt++;
                        mq.delete();
                    end
                end
            end
            if (a && !e_stall && !mism) begin
                e.pred = p;
                e.tgt  = tgt;
                e.ft   = pc + (c ? 32'd2 : 32'd4);
                mq.push_back(e);
            end
        end

        @(posedge clk);
        #1;
        drive_idle();
        tests_run += 4;
        if (mispredict_o !== m_mp) begin
            tests_failed++;
            $display("FAIL mispredict: got %b exp %b", mispredict_o, m_mp);
        end
        if (mispredict_pc_o !== m_mpc) begin
            tests_failed++;
            $display("FAIL mispredict_pc: got %h exp %h", mispredict_pc_o, m_mpc);
        end
        if (err_o !== m_err) begin
            tests_failed++;
            $display("FAIL err: got %b exp %b", err_o, m_err);
        end
        if (empty_o !== (mq.size() == 0)) begin
            tests_failed++;
            $display("FAIL empty_post: got %b exp %b", empty_o, mq.size() == 0);
        end
`ifdef CV32E40X_BCH_STATS_EN
        tests_run += 2;
        if (bch_cnt_o !== m_bcnt) begin
            tests_failed++;
            $display("FAIL bch_cnt: got %0d exp %0d", bch_cnt_o, m_bcnt);
        end
        if (mispred_cnt_o !== m_mcnt) begin
            tests_failed++;
            $display("FAIL mispred_cnt: got %0d exp %0d", mispred_cnt_o, m_mcnt);
        end
`endif
    endtask

    task automatic check_reset_values(input string tag);
        tests_run++;
        if (mispredict_o !== 1'b0 || mispredict_pc_o !== 32'h0 || err_o !== 1'b0 ||
            stall_id_o !== 1'b0 || empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s: mp=%b mpc=%h err=%b stall=%b empty=%b exp 0 0 0 0 1",
                     tag, mispredict_o, mispredict_pc_o, err_o, stall_id_o, empty_o);
        end
`ifdef CV32E40X_BCH_STATS_EN
        tests_run++;
        if (bch_cnt_o !== 32'h0 || mispred_cnt_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL %s_stats: bch=%0d mis=%0d exp 0 0", tag, bch_cnt_o, mispred_cnt_o);
        end
`endif
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 1'b1;
        #3;
        check_reset_values("reset_hold");
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        check_reset_values("reset_release");
    endtask

    task automatic test_mispredict_basic();
        step(1, 32'h100, 0, 32'h0F0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        tests_run++;
        if (mispredict_o !== 1'b1 || mispredict_pc_o !== 32'h104) begin
            tests_failed++;
            $display("FAIL nt_redirect: got %b/%h exp 1/00000104", mispredict_o, mispredict_pc_o);
        end
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(1, 32'h200, 1, 32'h240, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        tests_run++;
        if (mispredict_pc_o !== 32'h240) begin
            tests_failed++;
            $display("FAIL taken_redirect: got %h exp 00000240", mispredict_pc_o);
        end
        step(1, 32'h300, 0, 32'h280, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        tests_run++;
        if (mispredict_o !== 1'b0 || mispredict_pc_o !== 32'h240) begin
            tests_failed++;
            $display("FAIL correct_pred: got %b/%h exp 0/00000240", mispredict_o, mispredict_pc_o);
        end
        step(1, 32'hFFFF_FFFC, 0, 32'h80, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        tests_run++;
        if (mispredict_pc_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL pc_wrap: got %h exp 00000000", mispredict_pc_o);
        end
    endtask

    task automatic test_full_stall();
        step(1, 32'h400, 0, 32'h500, 0, 0, 0, 0);
        step(1, 32'h404, 0, 32'h504, 0, 0, 0, 0);
        step(1, 32'h408, 0, 32'h508, 0, 0, 0, 0);
        step(1, 32'h408, 0, 32'h508, 0, 1, 0, 0);
        tests_run++;
        if (empty_o !== 1'b0 || mq.size() != DEPTH) begin
            tests_failed++;
            $display("FAIL full_swap: empty=%b depth=%0d exp 0/%0d", empty_o, mq.size(), DEPTH);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
    endtask

    task automatic test_flush_err();
        step(1, 32'h600, 0, 32'h700, 0, 0, 0, 0);
        step(1, 32'h604, 0, 32'h704, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        tests_run++;
        if (empty_o !== 1'b1 || mispredict_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_younger: empty=%b mp=%b exp 1/1", empty_o, mispredict_o);
        end
        step(1, 32'h800, 0, 32'h900, 1, 0, 0, 0);
        step(1, 32'h804, 0, 32'h904, 1, 1, 0, 1);
        tests_run++;
        if (mispredict_o !== 1'b0 || empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL kill_suppress: mp=%b empty=%b exp 0/1", mispredict_o, empty_o);
        end
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL err_sticky: got %b exp 1", err_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 1)), {$urandom_range(0, 32'hFFFF), 16'h0} | 32'($urandom_range(0, 7) * 2),
                 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 45), 1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 4));
        end
    endtask

    task automatic test_stats();
`ifdef CV32E40X_BCH_STATS_EN
        test_reset();
        step(1, 32'hA00, 0, 32'hB00, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(1, 32'hA04, 0, 32'hB04, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 1, 0);
        step(1, 32'hA08, 0, 32'hB08, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        tests_run++;
        if (bch_cnt_o !== 32'd3 || mispred_cnt_o !== 32'd1) begin
            tests_failed++;
            $display("FAIL stats_count: bch=%0d mis=%0d exp 3/1", bch_cnt_o, mispred_cnt_o);
        end
`endif
    endtask

    task automatic test_reset_midrun();
        step(1, 32'hC00, 0, 32'hD00, 1, 0, 0, 0);
        step(1, 32'hC04, 0, 32'hD04, 1, 0, 0, 0);
        ex_bch_valid_i = 1'b1;
        ex_bch_taken_i = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_values("reset_midrun");
        @(posedge clk);
        #1;
        drive_idle();
        rst = 1'b0;
        model_clear();
        step(0, 0, 0, 0, 0, 0, 0, 0);
        tests_run++;
        if (mispredict_o !== 1'b0 || empty_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: mp=%b empty=%b exp 0/1", mispredict_o, empty_o);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        drive_idle();
        rst = 1'b0;
        model_clear();
        #2;
        test_reset();
        test_mispredict_basic();
        test_full_stall();
        test_flush_err();
        test_random();
        test_stats();
        test_reset_midrun();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/cv32e40x_bch_resolve.md
CV32E40X_BCH_RESOLVE -- requirements
Module: cv32e40x_bch_resolve

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high.
REQ-002 SHALL have parameter DEPTH, default 2, meaning number of in-flight branch entries (legal 1..4).
REQ-003 SHALL have ports:
- clk  input  1  clock, rising edge.
- rst  input  1  async active-high reset.
- id_bch_alloc_i  input  1  conditional branch leaves ID into EX this cycle.
- pc_id_i  input  32  PC of that branch.
- is_compressed_i  input  1  branch is 16-bit.
- bch_target_i  input  32  branch target from the ID target adder.
- bch_prediction_id_i  input  1  1 = predicted taken (backward target).
- ex_bch_valid_i  input  1  oldest branch resolved in EX this cycle.
- ex_bch_taken_i  input  1  actual outcome.
- kill_i  input  1  controller flush.
- pred_redirect_o  output  1  ID-stage redirect to predicted target.
- pred_target_o  output  32  predicted target.
- mispredict_o  output  1  registered misprediction redirect.
- mispredict_pc_o  output  32  corrected fetch PC.
- stall_id_o  output  1  table full, hold branch in ID.
- empty_o  output  1  no branch in flight.
- err_o  output  1  sticky: resolve with empty table.

Function
REQ-004 SHALL hold a DEPTH-entry FIFO; each entry stores prediction, target, and fall-through PC (pc_id_i + 2 if compressed, else + 4, modulo 2^32).
REQ-005 SHALL push an entry when id_bch_alloc_i=1 and stall_id_o=0; id_bch_alloc_i while stalled SHALL be ignored.
REQ-006 pred_redirect_o SHALL be combinational: id_bch_alloc_i & bch_prediction_id_i & ~stall_id_o & ~kill_i; pred_target_o = bch_target_i always.
REQ-007 SHALL pop the oldest entry when ex_bch_valid_i=1 and table non-empty.
REQ-008 On pop, a mismatch between stored prediction and ex_bch_taken_i SHALL set mispredict_o=1 for exactly one cycle, starting the following cycle (latency 1).
REQ-009 mispredict_pc_o SHALL be the stored target when actual taken, the stored fall-through when actual not-taken; it SHALL hold its value while mispredict_o=0.
REQ-010 A misprediction SHALL discard all younger entries (table empty next cycle); a push in the same cycle SHALL be dropped.
REQ-011 stall_id_o SHALL equal (count==DEPTH) & ~ex_bch_valid_i; with full table and simultaneous pop+push, pop SHALL precede push and count SHALL stay DEPTH.
REQ-012 Pointers SHALL wrap modulo DEPTH; count SHALL never exceed DEPTH nor underflow.
REQ-013 ex_bch_valid_i with empty table SHALL set err_o=1 (sticky until reset) and change no other state.
REQ-014 kill_i=1 SHALL empty the table next cycle, suppress any push and any mispredict_o for that cycle's pop; kill_i has priority over all events.
REQ-015 empty_o SHALL equal (count==0).

Reset
REQ-016 While rst=1: table empty, pointers 0, mispredict_o=0, mispredict_pc_o=0, err_o=0, stall_id_o=0, empty_o=1.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight entries immediately; no mispredict_o SHALL follow reset release.

Configuration
REQ-018 With CV32E40X_BCH_STATS_EN defined, SHALL add outputs bch_cnt_o[31:0] (pops) and mispred_cnt_o[31:0] (mispredictions), reset to 0, incremented on pop/mismatch, wrapping 0xFFFFFFFF->0, not incremented when kill_i=1.
REQ-019 Without CV32E40X_BCH_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-020 Push pc=0x100, 32-bit, target=0x0F0, pred=1 -> pred_redirect_o=1, pred_target_o=0x0F0; resolve not-taken -> next cycle mispredict_o=1, mispredict_pc_o=0x104.
REQ-021 Push pc=0x200, compressed, target=0x240, pred=0; resolve taken -> mispredict_pc_o=0x240; resolve of a correct prediction -> mispredict_o stays 0.
REQ-022 DEPTH=2: push two, third alloc -> stall_id_o=1; same cycle with ex_bch_valid_i=1 -> stall_id_o=0, count stays 2.
REQ-023 Push pc=0xFFFFFFFC 32-bit pred=1, resolve not-taken -> mispredict_pc_o=0x00000000.
REQ-024 Two entries, mispredict on oldest -> empty_o=1 next cycle; kill_i with pending mismatch -> no mispredict_o; resolve on empty -> err_o=1 held until rst.
REQ-025 With CV32E40X_BCH_STATS_EN: 3 pops, 1 mismatch -> bch_cnt_o=3, mispred_cnt_o=1; rst mid-run -> both 0.
